// File: rtl/ultrasonic_scheduler_pkg.sv
// Shared types and timing defaults for the ultrasonic ranger scheduler.
// Obstacle logic imports the same package for the us-to-cm conversion.
package ultrasonic_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } state_t;

    localparam int DEF_N_SENSORS    = 3;
    localparam int DEF_TRIG_US      = 10;
    localparam int DEF_ECHO_TIMEOUT = 30000;
    localparam int DEF_GAP_US       = 10000;
    localparam int DEF_CW           = 16;

    // Round-trip echo time per centimetre of range.
    localparam int US_PER_CM = 58;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int us_to_cm(input int us);
        return us / US_PER_CM;
    endfunction

endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// Sensor pins and measurement result bundle of the ranger scheduler.
// master = scheduler side, slave = pins/obstacle-logic side.
interface ultrasonic_scheduler_if
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int N_SENSORS = DEF_N_SENSORS,
    parameter int CW        = DEF_CW
);
    localparam int IW = id_width(N_SENSORS);

    logic                 en;
    logic [N_SENSORS-1:0] echo;
    logic [N_SENSORS-1:0] trig;
    logic                 busy;
    logic                 meas_valid;
    logic [IW-1:0]        meas_id;
    logic [CW-1:0]        meas_us;
    logic                 meas_timeout;

    modport master (
        input  en, echo,
        output trig, busy, meas_valid, meas_id, meas_us, meas_timeout
    );

    modport slave (
        output en, echo,
        input  trig, busy, meas_valid, meas_id, meas_us, meas_timeout
    );

endinterface

// File: rtl/ultrasonic_scheduler_echo_sync.sv
// Two-flop synchronizer for the raw asynchronous echo lines.
// Synchronous reset clears both stages.
module ultrasonic_scheduler_echo_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo sequencer for N ultrasonic rangers.
// One FSM and one shared timer; 1 cycle = 1 us.
module ultrasonic_scheduler
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int N_SENSORS    = DEF_N_SENSORS,
    parameter int TRIG_US      = DEF_TRIG_US,
    parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
    parameter int GAP_US       = DEF_GAP_US,
    parameter int CW           = DEF_CW
) (
    input  logic                  clk_1m,
    input  logic                  rst,
    ultrasonic_scheduler_if.master bus
);
    localparam int IW = id_width(N_SENSORS);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_US - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] TO_VAL    = CW'(ECHO_TIMEOUT);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_US - 1);
    localparam logic [IW-1:0] CUR_LAST  = IW'(N_SENSORS - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t               state_d, state_q;
    logic [CW-1:0]        timer_d, timer_q;
    logic [IW-1:0]        cur_d, cur_q;
    logic [N_SENSORS-1:0] trig_d, trig_q;
    logic                 busy_d, busy_q;
    logic                 meas_valid_d, meas_valid_q;
    logic [IW-1:0]        meas_id_d, meas_id_q;
    logic [CW-1:0]        meas_us_d, meas_us_q;
    logic                 meas_timeout_d, meas_timeout_q;

    logic [N_SENSORS-1:0] echo_s;
    logic                 echo_cur;

    ultrasonic_scheduler_echo_sync #(
        .W (N_SENSORS)
    ) u_echo_sync (
        .clk (clk_1m),
        .rst (rst),
        .d   (bus.echo),
        .q   (echo_s)
    );

    assign echo_cur = echo_s[cur_q];

    // Next state, shared timer, sensor index and result capture.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        cur_d          = cur_q;
        meas_valid_d   = 1'b0;
        meas_id_d      = meas_id_q;
        meas_us_d      = meas_us_q;
        meas_timeout_d = meas_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_TRIG;
                    timer_d = '0;
                end
            end
            ST_TRIG: begin
                if (timer_q >= TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    timer_d = '0;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            ST_WAIT_RISE: begin
                if (echo_cur) begin
                    state_d = ST_MEASURE;
                    timer_d = CW'(1);
                end else if (timer_q >= TO_LAST) begin
                    state_d        = ST_GAP;
                    timer_d        = '0;
                    meas_valid_d   = 1'b1;
                    meas_id_d      = cur_q;
                    meas_us_d      = TO_VAL;
                    meas_timeout_d = 1'b1;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            ST_MEASURE: begin
                if (!echo_cur) begin
                    state_d        = ST_GAP;
                    timer_d        = '0;
                    meas_valid_d   = 1'b1;
                    meas_id_d      = cur_q;
                    meas_us_d      = timer_q;
                    meas_timeout_d = 1'b0;
                end else if (timer_q >= TO_LAST) begin
                    // This high cycle brings the width to the limit.
                    state_d        = ST_GAP;
                    timer_d        = '0;
                    meas_valid_d   = 1'b1;
                    meas_id_d      = cur_q;
                    meas_us_d      = TO_VAL;
                    meas_timeout_d = 1'b1;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            ST_GAP: begin
                if (timer_q >= GAP_LAST) begin
                    timer_d = '0;
                    cur_d   = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
                    state_d = bus.en ? ST_TRIG : ST_IDLE;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        trig_d = '0;
        if (state_d == ST_TRIG) begin
            trig_d[cur_d] = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, timer, index and registered outputs.
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            cur_q          <= '0;
            trig_q         <= '0;
            busy_q         <= 1'b0;
            meas_valid_q   <= 1'b0;
            meas_id_q      <= '0;
            meas_us_q      <= '0;
            meas_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            cur_q          <= cur_d;
            trig_q         <= trig_d;
            busy_q         <= busy_d;
            meas_valid_q   <= meas_valid_d;
            meas_id_q      <= meas_id_d;
            meas_us_q      <= meas_us_d;
            meas_timeout_q <= meas_timeout_d;
        end
    end

    assign bus.trig         = trig_q;
    assign bus.busy         = busy_q;
    assign bus.meas_valid   = meas_valid_q;
    assign bus.meas_id      = meas_id_q;
    assign bus.meas_us      = meas_us_q;
    assign bus.meas_timeout = meas_timeout_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing.
// Table of per-sensor measurements plus en-drop and reset sequences.
module tb_ultrasonic_scheduler;
    localparam int N    = 3;
    localparam int TRIG = 10;
    localparam int TO   = 1000;
    localparam int GAP  = 100;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst;

    ultrasonic_scheduler_if #(.N_SENSORS(N), .CW(CW)) bus ();

    ultrasonic_scheduler #(
        .N_SENSORS    (N),
        .TRIG_US      (TRIG),
        .ECHO_TIMEOUT (TO),
        .GAP_US       (GAP),
        .CW           (CW)
    ) dut (
        .clk_1m (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int us;
        int to;
    } res_t;

    typedef struct {
        int sensor;
        int delay;
        int width;
        bit noise;
        bit stuck;
        bit drop;
        int exp_us;
        int exp_to;
    } vec_t;

    res_t res_q[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad = 0;
    int   onehot_err = 0;
    int   pulse_err = 0;
    bit   mv_prev = 1'b0;

    // Result capture and per-cycle protocol monitors.
    always @(negedge clk) begin
        if (bus.meas_valid) begin
            res_q.push_back('{int'(bus.meas_id), int'(bus.meas_us),
                              int'(bus.meas_timeout)});
        end
        if ($countones(bus.trig) > 1) onehot_err++;
        if (bus.meas_valid && mv_prev) pulse_err++;
        mv_prev = bus.meas_valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_trig(output int idx);
        idx = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.trig != '0) begin
                for (int b = 0; b < N; b++) begin
                    if (bus.trig[b]) idx = b;
                end
                return;
            end
        end
    endtask

    task automatic trig_len(output int len);
        len = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.trig == '0) return;
            len++;
        end
    endtask

    task automatic wait_result(output res_t r);
        r = '{-1, -1, -1};
        for (int n = 0; n < 3000; n++) begin
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_echo(input vec_t v);
        int o;
        o = (v.sensor + 1) % N;
        for (int k = 0; k < v.delay; k++) @(negedge clk);
        bus.echo[v.sensor] = 1'b1;
        for (int k = 0; k < v.width; k++) begin
            @(negedge clk);
            if (v.noise) begin
                bus.echo[o] = (k >= v.width / 4) && (k < v.width / 2);
            end
            if (v.drop && k == v.width / 2) bus.en = 1'b0;
        end
        bus.echo[v.sensor] = 1'b0;
        if (v.noise) bus.echo[o] = 1'b0;
    endtask

    task automatic run_step(input vec_t v);
        int   idx;
        int   len;
        res_t r;
        if (v.stuck) bus.echo[v.sensor] = 1'b1;
        wait_trig(idx);
        chk("trig_idx", idx, v.sensor);
        trig_len(len);
        chk("trig_len", len, TRIG);
        if (v.delay >= 0 && !v.stuck) drive_echo(v);
        wait_result(r);
        if (v.stuck) bus.echo[v.sensor] = 1'b0;
        chk("meas_id", r.id, v.sensor);
        chk("meas_us", r.us, v.exp_us);
        chk("meas_timeout", r.to, v.exp_to);
    endtask

    initial begin
        int   idx;
        int   len;
        int   cnt;
        res_t r;

        vecs[0] = '{0, 200, 580, 1'b0, 1'b0, 1'b0, 580, 0};
        vecs[1] = '{1, -1, 0, 1'b0, 1'b0, 1'b0, TO, 1};
        vecs[2] = '{2, -1, 0, 1'b0, 1'b0, 1'b0, TO, 1};
        vecs[3] = '{0, 50, 300, 1'b1, 1'b0, 1'b0, 300, 0};
        vecs[4] = '{1, 0, 0, 1'b0, 1'b1, 1'b0, TO, 1};
        vecs[5] = '{2, 0, 1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[6] = '{0, 10, TO - 1, 1'b0, 1'b0, 1'b0, TO - 1, 0};
        vecs[7] = '{1, 10, TO, 1'b0, 1'b0, 1'b0, TO, 1};
        vecs[8] = '{2, -1, 0, 1'b0, 1'b0, 1'b0, TO, 1};
        vecs[9] = '{0, 20, 400, 1'b0, 1'b0, 1'b1, 400, 0};

        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.echo = '0;
        repeat (3) @(negedge clk);
        chk("rst_trig", int'(bus.trig), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.meas_valid), 0);
        chk("rst_us", int'(bus.meas_us), 0);
        chk("rst_id", int'(bus.meas_id), 0);
        chk("rst_timeout", int'(bus.meas_timeout), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_trig", int'(bus.trig), 0);

        bus.en = 1'b1;
        for (int i = 0; i < 10; i++) run_step(vecs[i]);

        cnt = 0;
        while (bus.busy && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        chk("drop_busy", int'(bus.busy), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.trig != '0 || bus.busy) cnt++;
        end
        chk("drop_stay_idle", cnt, 0);

        bus.en = 1'b1;
        wait_trig(idx);
        chk("resume_idx", idx, 1);
        trig_len(len);
        wait_result(r);
        chk("resume_id", r.id, 1);
        chk("resume_us", r.us, TO);

        wait_trig(idx);
        chk("pre_rst_idx", idx, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_trig", int'(bus.trig), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_valid", int'(bus.meas_valid), 0);
        chk("mid_rst_us", int'(bus.meas_us), 0);
        chk("mid_rst_timeout", int'(bus.meas_timeout), 0);
        rst = 1'b0;
        wait_trig(idx);
        chk("post_rst_idx", idx, 0);
        chk("post_rst_no_emit", res_q.size(), 0);
        bus.en = 1'b0;

        chk("trig_onehot", onehot_err, 0);
        chk("valid_one_cycle", pulse_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
